track_segment_arbiter: RTL and testbench
========================================

# track_segment_arbiter

Arbiter for a single shared track segment requested from two approach sides (A and B), sitting between the input synchronizer and the signal/output stage of the train controller. It grants the segment to one side at a time with round-robin priority, tracks occupancy from entry/exit sensor pulses, and enforces a grant timeout and a post-exit guard interval. Inconsistent sensor sequences latch a fault state that holds both signals red until the fault is explicitly cleared.

## Interface
- GRANT_TIMEOUT, 1000: cycles a grant stays open waiting for an entry pulse.
- CLEAR_CYCLES, 200: guard cycles after exit before the next grant.
- CNT_W, 16: internal counter width; must hold max(GRANT_TIMEOUT, CLEAR_CYCLES).

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_a  in  1  level request from side A, held until granted.
- req_b  in  1  level request from side B, held until granted.
- enter  in  1  one-cycle pulse: a train entered the segment (synchronized).
- leave  in  1  one-cycle pulse: a train left the segment (synchronized).
- clear_fault  in  1  level; leaves FAULT when sampled high.
- green_a  out  1  proceed signal for side A.
- green_b  out  1  proceed signal for side B.
- occupied  out  1  segment occupied.
- timeout  out  1  one-cycle pulse when a grant expires unused.
- fault  out  1  high while in FAULT.
- prio  out  1  side favoured on a tie (0 = A, 1 = B).
- state  out  3  current state code, for the display stage.

## Operation
- States and codes: IDLE=0, GRANT_A=1, GRANT_B=2, OCC_A=3, OCC_B=4, CLEAR=5, FAULT=6; code 7 is illegal and recovers to IDLE on the next edge.
- Outputs are a combinational decode of the state register: green_a=(GRANT_A), green_b=(GRANT_B), occupied=(OCC_A|OCC_B), fault=(FAULT). timeout and prio are registered.
- IDLE: req_a only -> GRANT_A; req_b only -> GRANT_B; both -> side given by prio; neither -> stay. enter or leave pulse in IDLE -> FAULT (takes precedence over requests).
- On every transition into GRANT_x, prio is set to the opposite side (round-robin on grant, not on completion).
- GRANT_x: the counter runs from 0. enter alone -> OCC_x. leave (with or without enter) -> FAULT. The counter reaching GRANT_TIMEOUT-1 with no pulse -> CLEAR and timeout=1 for one cycle. enter on the expiry cycle wins -> OCC_x, no timeout.
- OCC_x: leave alone -> CLEAR. enter (with or without leave) -> FAULT; a second train is a fault.
- CLEAR: the counter runs from 0. Reaching CLEAR_CYCLES-1 -> IDLE. enter or leave during CLEAR -> FAULT. Requests are ignored in CLEAR.
- FAULT: both greens low. clear_fault=1 -> CLEAR, so the guard interval always precedes re-arbitration. Pulses are ignored in FAULT.
- The counter resets to 0 on every state change and saturates at its terminal value; there is no wrap.

## Timing
- Reset values: state=IDLE, counter=0, prio=0, timeout=0; hence green_a=green_b=occupied=fault=0.
- Reset is honoured mid-operation in any state; outputs go to reset values immediately, without waiting for a clock edge.
- Request latency: a request sampled at edge k gives a state change at edge k and green high in the same cycle following k.
- Grant window: exactly GRANT_TIMEOUT cycles of green when unused; timeout is asserted in the first CLEAR cycle.
- Guard: exactly CLEAR_CYCLES cycles in CLEAR, then one IDLE cycle minimum before the next GRANT. Minimum request-to-request turnaround after leave is CLEAR_CYCLES+1 cycles.
- enter and leave are treated as single-cycle pulses. A pulse held high for N cycles counts as N events, so a held enter in OCC forces FAULT.

## Test plan
- Reset then req_a=1 -> green_a=1 one cycle after the edge, state=1, prio=1. enter -> state=3, green_a=0, occupied=1. leave -> state=5. After 200 cycles -> state=0.
- req_a=req_b=1 from reset -> GRANT_A. After the full cycle completes with both still high -> GRANT_B, prio=0. Sides alternate over 4 rounds.
- req_b only, no enter -> green_b high for exactly 1000 cycles, timeout pulse in the first CLEAR cycle, IDLE after 200 more cycles.
- In OCC_A, inject enter -> state=6, fault=1, both greens 0. Hold clear_fault=0 for 50 cycles -> stays 6. clear_fault=1 -> CLEAR, then IDLE after 200 cycles.
- leave in IDLE -> FAULT. enter coincident with the expiry cycle of GRANT_A -> OCC_A, timeout stays 0.
- Assert rst asynchronously mid-GRANT_B, between edges -> green_b drops without a clock edge, state=0, prio=0.

Source files
------------

// File: rtl/track_segment_arbiter.sv
// Track segment arbiter: grants one shared segment to side A or B with
// round-robin tie-breaking, follows occupancy from enter/leave pulses, and
// enforces a grant timeout, a post-exit guard interval and a latched fault.
module track_segment_arbiter #(
    parameter int GRANT_TIMEOUT = 1000,
    parameter int CLEAR_CYCLES  = 200,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_a,
    input  logic       req_b,
    input  logic       enter,
    input  logic       leave,
    input  logic       clear_fault,
    output logic       green_a,
    output logic       green_b,
    output logic       occupied,
    output logic       timeout,
    output logic       fault,
    output logic       prio,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GRANT_A = 3'd1,
        GRANT_B = 3'd2,
        OCC_A   = 3'd3,
        OCC_B   = 3'd4,
        CLEAR   = 3'd5,
        FAULT   = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] GRANT_LAST = CNT_W'(GRANT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           cur_state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_limit;
    logic             next_timeout;

    // State register; an async reset returns everything to IDLE at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= next_state;
        end
    end

    // Window counter: restarts on any state change, saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (next_state != cur_state) begin
            cnt <= '0;
        end else if (cnt != cnt_limit) begin
            cnt <= cnt + CNT_ONE;
        end
    end

    // Round-robin pointer flips on each grant; timeout is a registered pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio    <= 1'b0;
            timeout <= 1'b0;
        end else begin
            timeout <= next_timeout;
            if (next_state != cur_state) begin
                if (next_state == GRANT_A) begin
                    prio <= 1'b1;
                end else if (next_state == GRANT_B) begin
                    prio <= 1'b0;
                end
            end
        end
    end

    // Terminal count for the counter in the timed states.
    always_comb begin
        cnt_limit = '0;
        case (cur_state)
            GRANT_A, GRANT_B: cnt_limit = GRANT_LAST;
            CLEAR:            cnt_limit = CLEAR_LAST;
            default:          cnt_limit = '0;
        endcase
    end

    // Next-state logic: sensor inconsistencies win over requests and timers.
    always_comb begin
        next_state   = cur_state;
        next_timeout = 1'b0;
        case (cur_state)
            IDLE: begin
                if (enter || leave) begin
                    next_state = FAULT;
                end else if (req_a && req_b) begin
                    next_state = prio ? GRANT_B : GRANT_A;
                end else if (req_a) begin
                    next_state = GRANT_A;
                end else if (req_b) begin
                    next_state = GRANT_B;
                end
            end
            GRANT_A, GRANT_B: begin
                if (leave) begin
                    next_state = FAULT;
                end else if (enter) begin
                    next_state = (cur_state == GRANT_A) ? OCC_A : OCC_B;
                end else if (cnt == GRANT_LAST) begin
                    next_state   = CLEAR;
                    next_timeout = 1'b1;
                end
            end
            OCC_A, OCC_B: begin
                if (enter) begin
                    next_state = FAULT;
                end else if (leave) begin
                    next_state = CLEAR;
                end
            end
            CLEAR: begin
                if (enter || leave) begin
                    next_state = FAULT;
                end else if (cnt == CLEAR_LAST) begin
                    next_state = IDLE;
                end
            end
            FAULT: begin
                if (clear_fault) begin
                    next_state = CLEAR;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Signal outputs decode straight from the state register.
    always_comb begin
        green_a  = (cur_state == GRANT_A);
        green_b  = (cur_state == GRANT_B);
        occupied = (cur_state == OCC_A) || (cur_state == OCC_B);
        fault    = (cur_state == FAULT);
        state    = cur_state;
    end

endmodule

// File: tb/tb_track_segment_arbiter.sv
// Self-checking bench for track_segment_arbiter: directed scenarios plus a
// randomized run compared cycle by cycle against a behavioural model.
module tb_track_segment_arbiter;

    localparam int GRANT_TIMEOUT = 1000;
    localparam int CLEAR_CYCLES  = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a = 1'b0;
    logic       req_b = 1'b0;
    logic       enter = 1'b0;
    logic       leave = 1'b0;
    logic       clear_fault = 1'b0;
    logic       green_a;
    logic       green_b;
    logic       occupied;
    logic       timeout;
    logic       fault;
    logic       prio;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Model: phase code, cycles left in the current timed window, pointer.
    int m_state   = 0;
    int m_left    = 0;
    bit m_prio    = 1'b0;
    bit m_timeout = 1'b0;

    track_segment_arbiter #(
        .GRANT_TIMEOUT(GRANT_TIMEOUT),
        .CLEAR_CYCLES (CLEAR_CYCLES),
        .CNT_W        (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_a      (req_a),
        .req_b      (req_b),
        .enter      (enter),
        .leave      (leave),
        .clear_fault(clear_fault),
        .green_a    (green_a),
        .green_b    (green_b),
        .occupied   (occupied),
        .timeout    (timeout),
        .fault      (fault),
        .prio       (prio),
        .state      (state)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    task automatic model_reset();
        m_state   = 0;
        m_left    = 0;
        m_prio    = 1'b0;
        m_timeout = 1'b0;
    endtask

    task automatic model_go(input int s);
        m_state = s;
        if (s == 1 || s == 2) begin
            m_left = GRANT_TIMEOUT;
            m_prio = (s == 1);
        end else if (s == 5) begin
            m_left = CLEAR_CYCLES;
        end
    endtask

    task automatic model_edge();
        m_timeout = 1'b0;
        case (m_state)
            0: begin
                if (enter || leave) model_go(6);
                else if (req_a && req_b) model_go(m_prio ? 2 : 1);
                else if (req_a) model_go(1);
                else if (req_b) model_go(2);
            end
            1, 2: begin
                if (leave) model_go(6);
                else if (enter) model_go(m_state + 2);
                else begin
                    m_left--;
                    if (m_left == 0) begin
                        model_go(5);
                        m_timeout = 1'b1;
                    end
                end
            end
            3, 4: begin
                if (enter) model_go(6);
                else if (leave) model_go(5);
            end
            5: begin
                if (enter || leave) model_go(6);
                else begin
                    m_left--;
                    if (m_left == 0) model_go(0);
                end
            end
            6: begin
                if (clear_fault) model_go(5);
            end
            default: model_go(0);
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req_a = 1'b0; req_b = 1'b0; enter = 1'b0; leave = 1'b0; clear_fault = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({state, green_a, green_b, occupied, fault, timeout, prio} !== 9'd0) begin
            $display("[TB] FAIL reset_values: got state=%0d ga=%b gb=%b occ=%b flt=%b to=%b prio=%b required all 0",
                     state, green_a, green_b, occupied, fault, timeout, prio);
            errors++;
        end
        tick();
        checks++;
        if (state !== 3'd0) begin
            $display("[TB] FAIL reset_idle_hold: got state=%0d required 0", state);
            errors++;
        end
    endtask

    task automatic test_basic_cycle();
        do_reset();
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        checks++;
        if (state !== 3'd1 || green_a !== 1'b1 || prio !== 1'b1) begin
            $display("[TB] FAIL basic_grant: got state=%0d ga=%b prio=%b required 1 1 1", state, green_a, prio);
            errors++;
        end
        enter = 1'b1;
        tick();
        enter = 1'b0;
        checks++;
        if (state !== 3'd3 || green_a !== 1'b0 || occupied !== 1'b1) begin
            $display("[TB] FAIL basic_occ: got state=%0d ga=%b occ=%b required 3 0 1", state, green_a, occupied);
            errors++;
        end
        leave = 1'b1;
        tick();
        leave = 1'b0;
        checks++;
        if (state !== 3'd5 || occupied !== 1'b0) begin
            $display("[TB] FAIL basic_clear: got state=%0d occ=%b required 5 0", state, occupied);
            errors++;
        end
        repeat (CLEAR_CYCLES - 1) tick();
        checks++;
        if (state !== 3'd5) begin
            $display("[TB] FAIL basic_clear_len: got state=%0d required 5", state);
            errors++;
        end
        tick();
        checks++;
        if (state !== 3'd0) begin
            $display("[TB] FAIL basic_idle: got state=%0d required 0", state);
            errors++;
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        req_a = 1'b1;
        req_b = 1'b1;
        for (int r = 0; r < 4; r++) begin
            tick();
            checks++;
            if (state !== ((r % 2 == 0) ? 3'd1 : 3'd2) || prio !== ((r % 2 == 0) ? 1'b1 : 1'b0)) begin
                $display("[TB] FAIL rr_round%0d: got state=%0d prio=%b required %0d %0d",
                         r, state, prio, (r % 2 == 0) ? 1 : 2, (r % 2 == 0) ? 1 : 0);
                errors++;
            end
            enter = 1'b1;
            tick();
            enter = 1'b0;
            leave = 1'b1;
            tick();
            leave = 1'b0;
            repeat (CLEAR_CYCLES) tick();
            checks++;
            if (state !== 3'd0) begin
                $display("[TB] FAIL rr_idle%0d: got state=%0d required 0", r, state);
                errors++;
            end
        end
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        req_b = 1'b1;
        tick();
        req_b = 1'b0;
        checks++;
        if (state !== 3'd2 || green_b !== 1'b1 || prio !== 1'b0) begin
            $display("[TB] FAIL to_grant: got state=%0d gb=%b prio=%b required 2 1 0", state, green_b, prio);
            errors++;
        end
        repeat (GRANT_TIMEOUT - 1) tick();
        checks++;
        if (green_b !== 1'b1 || timeout !== 1'b0) begin
            $display("[TB] FAIL to_last_green: got gb=%b to=%b required 1 0", green_b, timeout);
            errors++;
        end
        tick();
        checks++;
        if (state !== 3'd5 || green_b !== 1'b0 || timeout !== 1'b1) begin
            $display("[TB] FAIL to_expire: got state=%0d gb=%b to=%b required 5 0 1", state, green_b, timeout);
            errors++;
        end
        tick();
        checks++;
        if (timeout !== 1'b0) begin
            $display("[TB] FAIL to_pulse_width: got to=%b required 0", timeout);
            errors++;
        end
        repeat (CLEAR_CYCLES - 2) tick();
        checks++;
        if (state !== 3'd5) begin
            $display("[TB] FAIL to_clear_len: got state=%0d required 5", state);
            errors++;
        end
        tick();
        checks++;
        if (state !== 3'd0) begin
            $display("[TB] FAIL to_idle: got state=%0d required 0", state);
            errors++;
        end
    endtask

    task automatic test_fault_in_occ();
        do_reset();
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        enter = 1'b1;
        tick();
        tick();
        enter = 1'b0;
        checks++;
        if (state !== 3'd6 || fault !== 1'b1 || green_a !== 1'b0 || green_b !== 1'b0) begin
            $display("[TB] FAIL occ_fault: got state=%0d flt=%b ga=%b gb=%b required 6 1 0 0",
                     state, fault, green_a, green_b);
            errors++;
        end
        req_b = 1'b1;
        enter = 1'b1;
        repeat (50) tick();
        req_b = 1'b0;
        enter = 1'b0;
        checks++;
        if (state !== 3'd6 || green_b !== 1'b0) begin
            $display("[TB] FAIL fault_hold: got state=%0d gb=%b required 6 0", state, green_b);
            errors++;
        end
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        checks++;
        if (state !== 3'd5 || fault !== 1'b0) begin
            $display("[TB] FAIL fault_clear: got state=%0d flt=%b required 5 0", state, fault);
            errors++;
        end
        repeat (CLEAR_CYCLES) tick();
        checks++;
        if (state !== 3'd0) begin
            $display("[TB] FAIL fault_idle: got state=%0d required 0", state);
            errors++;
        end
    endtask

    task automatic test_idle_leave_and_expiry_enter();
        do_reset();
        leave = 1'b1;
        tick();
        leave = 1'b0;
        checks++;
        if (state !== 3'd6) begin
            $display("[TB] FAIL idle_leave: got state=%0d required 6", state);
            errors++;
        end
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        repeat (CLEAR_CYCLES) tick();
        req_a = 1'b1;
        tick();
        req_a = 1'b0;
        checks++;
        if (state !== 3'd1) begin
            $display("[TB] FAIL expiry_grant: got state=%0d required 1", state);
            errors++;
        end
        repeat (GRANT_TIMEOUT - 1) tick();
        enter = 1'b1;
        tick();
        enter = 1'b0;
        checks++;
        if (state !== 3'd3 || timeout !== 1'b0) begin
            $display("[TB] FAIL expiry_enter: got state=%0d to=%b required 3 0", state, timeout);
            errors++;
        end
        tick();
        checks++;
        if (timeout !== 1'b0 || state !== 3'd3) begin
            $display("[TB] FAIL expiry_no_pulse: got state=%0d to=%b required 3 0", state, timeout);
            errors++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req_b = 1'b1;
        tick();
        req_b = 1'b0;
        repeat (10) tick();
        checks++;
        if (state !== 3'd2 || green_b !== 1'b1) begin
            $display("[TB] FAIL async_pre: got state=%0d gb=%b required 2 1", state, green_b);
            errors++;
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (green_b !== 1'b0 || state !== 3'd0 || prio !== 1'b0) begin
            $display("[TB] FAIL async_reset: got state=%0d gb=%b prio=%b required 0 0 0", state, green_b, prio);
            errors++;
        end
        model_reset();
        #3;
        rst = 1'b0;
    endtask

    task automatic test_random();
        int shown;
        shown = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            req_a       = 1'($urandom_range(0, 1));
            req_b       = 1'($urandom_range(0, 1));
            enter       = ($urandom_range(0, 39) == 0);
            leave       = ($urandom_range(0, 39) == 0);
            clear_fault = ($urandom_range(0, 15) == 0);
            tick();
            checks++;
            if (int'(state) != m_state || green_a !== (m_state == 1) || green_b !== (m_state == 2) ||
                occupied !== (m_state == 3 || m_state == 4) || fault !== (m_state == 6) ||
                timeout !== m_timeout || prio !== m_prio) begin
                errors++;
                if (shown < 20) begin
                    shown++;
                    $display("[TB] FAIL random_cycle%0d: got state=%0d ga=%b gb=%b occ=%b flt=%b to=%b prio=%b required state=%0d to=%b prio=%b",
                             i, state, green_a, green_b, occupied, fault, timeout, prio, m_state, m_timeout, m_prio);
                end
            end
        end
        req_a = 1'b0; req_b = 1'b0; enter = 1'b0; leave = 1'b0; clear_fault = 1'b0;
    endtask

    // Scenario sequence followed by the single summary line.
    initial begin
        test_reset();
        test_basic_cycle();
        test_round_robin();
        test_timeout();
        test_fault_in_occ();
        test_idle_leave_and_expiry_enter();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
